// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared types and constants for the LED sequencer slice.
//   mode_t      : sequencer modes, in advance order OFF -> BLINK -> CHASE -> COUNT
//   ENTRY_*     : LED pattern loaded when a mode is entered
//   SW_IDX_*    : bit positions of the switches in the conditioned switch vector
//   next_mode   : mode that follows a given mode (wraps COUNT -> OFF)
//   entry_leds  : entry pattern for a mode
//   step_leds   : pattern after one step in a mode
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  localparam logic [3:0] ENTRY_OFF   = 4'b0000;
  localparam logic [3:0] ENTRY_BLINK = 4'b0000;
  localparam logic [3:0] ENTRY_CHASE = 4'b0001;
  localparam logic [3:0] ENTRY_COUNT = 4'b0000;

  localparam int NUM_SW      = 2;
  localparam int SW_IDX_MODE = 0;
  localparam int SW_IDX_RUN  = 1;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    n = MODE_OFF;
    case (m)
      MODE_OFF:   n = MODE_BLINK;
      MODE_BLINK: n = MODE_CHASE;
      MODE_CHASE: n = MODE_COUNT;
      MODE_COUNT: n = MODE_OFF;
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] entry_leds(input mode_t m);
    logic [3:0] p;
    p = ENTRY_OFF;
    case (m)
      MODE_OFF:   p = ENTRY_OFF;
      MODE_BLINK: p = ENTRY_BLINK;
      MODE_CHASE: p = ENTRY_CHASE;
      MODE_COUNT: p = ENTRY_COUNT;
      default:    p = ENTRY_OFF;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] step_leds(input mode_t m, input logic [3:0] l);
    logic [3:0] p;
    p = 4'b0000;
    case (m)
      MODE_OFF:   p = 4'b0000;
      MODE_BLINK: p = ~l;
      MODE_CHASE: p = {l[2:0], l[3]};
      MODE_COUNT: p = l + 4'd1;
      default:    p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
// Conditions one asynchronous switch: 2-FF synchronizer, optionally followed
// by a stability filter.
// Optional feature macro: LED_SEQ_DEBOUNCE_EN
//   defined   : o_sw follows the synchronized value only after it has differed
//               from o_sw for DEBOUNCE_CYC consecutive cycles
//   undefined : o_sw is the synchronizer output; DEBOUNCE_CYC has no effect
// Ports:
//   i_clk  : clock, rising edge
//   i_nrst : asynchronous active-low reset (all state to 0)
//   i_sw   : raw asynchronous switch
//   o_sw   : conditioned switch level
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_sw,
  output logic o_sw
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_out;

  // r_cnt counts consecutive cycles in which the synchronized level disagrees
  // with the output; any agreement restarts the window, so short glitches die.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (r_sync2 == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_out <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_sw = r_out;
`else
  // The stability window plays no role in this build.
  logic w_unused_debounce_cyc;
  assign w_unused_debounce_cyc = (DEBOUNCE_CYC > 0);

  assign o_sw = r_sync2;
`endif

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer
// Four-LED pattern sequencer with a mode switch and a run switch.
// Optional feature macro: LED_SEQ_DEBOUNCE_EN (switch stability filtering in
// sw_debounce; without it switches are only synchronized).
// Parameters:
//   CLK_HZ       : fpga_CLK_AUX frequency in Hz
//   TICK_HZ      : pattern step rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//   DEBOUNCE_CYC : switch stability window in cycles (>= 1)
// Ports:
//   fpga_CLK_AUX : clock, rising edge
//   fpga_NRST    : asynchronous active-low reset
//   sw_mode      : async switch, each rising edge advances the mode
//   sw_run       : async switch, 1 = run, 0 = freeze pattern
//   leds         : registered LED pattern
//   mode         : registered current mode
//   tick         : registered one-cycle step strobe
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int TICK_HZ      = 1,
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic       fpga_CLK_AUX,
  input  logic       fpga_NRST,
  input  logic       sw_mode,
  input  logic       sw_run,
  output logic [3:0] leds,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Cycles after reset release during which mode edges are discarded: long
  // enough for the conditioned sw_mode to reach the real switch level, so a
  // switch already held high at release does not look like a fresh press.
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int SETTLE_CYC = DEBOUNCE_CYC + 4;
`else
  localparam int SETTLE_CYC = 4;
`endif
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC);

  logic [NUM_SW-1:0] w_sw_raw;
  logic [NUM_SW-1:0] w_sw_cond;

  assign w_sw_raw[SW_IDX_MODE] = sw_mode;
  assign w_sw_raw[SW_IDX_RUN]  = sw_run;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sw_debounce (
      .i_clk (fpga_CLK_AUX),
      .i_nrst(fpga_NRST),
      .i_sw  (w_sw_raw[gi]),
      .o_sw  (w_sw_cond[gi])
    );
  end

  mode_t          r_mode;
  logic [3:0]     r_leds;
  logic [PW-1:0]  r_presc;
  logic           r_tick;
  logic           r_mode_prev;
  logic [SCW-1:0] r_settle_cnt;

  mode_t          w_mode_next;
  logic [3:0]     w_leds_next;
  logic [PW-1:0]  w_presc_next;
  logic           w_tick_next;
  logic           w_run;
  logic           w_settled;
  logic           w_mode_rise;

  assign w_run       = w_sw_cond[SW_IDX_RUN];
  assign w_settled   = (r_settle_cnt == SETTLE_LAST);
  assign w_mode_rise = w_sw_cond[SW_IDX_MODE] & ~r_mode_prev & w_settled;

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      r_mode       <= MODE_OFF;
      r_leds       <= 4'b0000;
      r_presc      <= '0;
      r_tick       <= 1'b0;
      r_mode_prev  <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      r_mode      <= w_mode_next;
      r_leds      <= w_leds_next;
      r_presc     <= w_presc_next;
      r_tick      <= w_tick_next;
      r_mode_prev <= w_sw_cond[SW_IDX_MODE];
      if (!w_settled) begin
        r_settle_cnt <= r_settle_cnt + SCW'(1);
      end
    end
  end

  // A mode edge takes priority over everything: it restarts the prescaler
  // and swallows a tick that lands in the same cycle.
  always_comb begin
    w_mode_next  = r_mode;
    w_leds_next  = r_leds;
    w_presc_next = r_presc;
    w_tick_next  = 1'b0;
    if (w_mode_rise) begin
      w_mode_next  = next_mode(r_mode);
      w_leds_next  = entry_leds(next_mode(r_mode));
      w_presc_next = '0;
    end else if (w_run) begin
      if (r_tick) begin
        w_leds_next = step_leds(r_mode, r_leds);
      end
      if (r_presc == PRESC_LAST) begin
        w_presc_next = '0;
        w_tick_next  = 1'b1;
      end else begin
        w_presc_next = r_presc + PW'(1);
      end
    end
  end

  assign leds = r_leds;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer
// Directed bench for led_sequencer with CLK_HZ=8, TICK_HZ=1 (DIV=8),
// DEBOUNCE_CYC=4. Expected mode/leds pairs are queued when stimulus is applied
// and popped when the DUT should present them. Expectations follow the
// LED_SEQ_DEBOUNCE_EN setting of the build.
module tb_led_sequencer;

  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 1;
  localparam int DEB_CYC = 4;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  // Clock edges from driving sw_mode high to the edge that changes mode.
  localparam int LAT = DEB ? 7 : 3;

  logic       clk = 1'b0;
  logic       nrst;
  logic       sw_mode;
  logic       sw_run;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .DEBOUNCE_CYC(DEB_CYC)
  ) dut (
    .fpga_CLK_AUX(clk),
    .fpga_NRST   (nrst),
    .sw_mode     (sw_mode),
    .sw_run      (sw_run),
    .leds        (leds),
    .mode        (mode),
    .tick        (tick)
  );

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic [3:0] leds;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [1:0] m, input logic [3:0] l);
    exp_t e;
    e.tag  = tag;
    e.mode = m;
    e.leds = l;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_mode"}, mode, e.mode);
      check({e.tag, "_leds"}, leds, e.leds);
      $display("txn %-14s mode=%0d leds=%b (exp mode=%0d leds=%b)", e.tag, mode, leds, e.mode, e.leds);
    end
  endtask

  // Returns at the negedge where tick is seen high; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) check("tick_timeout", tick, 1);
  endtask

  // Tick seen, then one cycle later the stepped pattern must be present.
  task automatic tick_step();
    int n;
    wait_tick(n);
    @(negedge clk);
    pop_check();
    check("tick_width", tick, 0);
  endtask

  task automatic mode_pulse(input string tag);
    logic [3:0] e_leds;
    exp_mode = (exp_mode + 1) % 4;
    e_leds   = (exp_mode == 2) ? 4'b0001 : 4'b0000;
    push_exp(tag, 2'(exp_mode), e_leds);
    sw_mode = 1'b1;
    repeat (10) @(negedge clk);
    sw_mode = 1'b0;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int bad_leds;
    int tick_cnt;

    nrst    = 1'b0;
    sw_mode = 1'b0;
    sw_run  = 1'b0;
    repeat (3) @(negedge clk);
    push_exp("reset", 2'd0, 4'b0000);
    pop_check();
    check("reset_tick", tick, 0);

    // OFF with run=1: ticks every 8 cycles, pattern stays dark.
    nrst   = 1'b1;
    sw_run = 1'b1;
    push_exp("off_t1", 2'd0, 4'b0000);
    tick_step();
    wait_tick(n);
    check("tick_period", n, 7);
    push_exp("off_t2", 2'd0, 4'b0000);
    @(negedge clk);
    pop_check();

    // BLINK
    mode_pulse("blink_entry");
    push_exp("blink_t1", 2'd1, 4'b1111);
    push_exp("blink_t2", 2'd1, 4'b0000);
    repeat (2) tick_step();

    // CHASE
    mode_pulse("chase_entry");
    push_exp("chase_t1", 2'd2, 4'b0010);
    push_exp("chase_t2", 2'd2, 4'b0100);
    push_exp("chase_t3", 2'd2, 4'b1000);
    push_exp("chase_t4", 2'd2, 4'b0001);
    push_exp("chase_t5", 2'd2, 4'b0010);
    repeat (5) tick_step();

    // COUNT up to 0101, then freeze
    mode_pulse("count_entry");
    push_exp("count_t1", 2'd3, 4'b0001);
    push_exp("count_t2", 2'd3, 4'b0010);
    push_exp("count_t3", 2'd3, 4'b0011);
    push_exp("count_t4", 2'd3, 4'b0100);
    push_exp("count_t5", 2'd3, 4'b0101);
    repeat (5) tick_step();
    sw_run   = 1'b0;
    bad_leds = 0;
    tick_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (leds !== 4'b0101) bad_leds++;
      if (tick !== 1'b0) tick_cnt++;
    end
    check("hold_leds_bad_cycles", bad_leds, 0);
    check("hold_tick_count", tick_cnt, 0);
    check("hold_leds_end", leds, 4'b0101);
    sw_run = 1'b1;
    push_exp("count_resume", 2'd3, 4'b0110);
    tick_step();

    // 3-cycle glitch: filtered with debounce, a real edge without it.
    // With debounce, COUNT takes exactly one more step in this window.
    sw_mode = 1'b1;
    repeat (3) @(negedge clk);
    sw_mode = 1'b0;
    repeat (12) @(negedge clk);
    if (!DEB) exp_mode = 0;
    push_exp("glitch", 2'(exp_mode), DEB ? 4'b0111 : 4'b0000);
    pop_check();

    while (exp_mode != 1) mode_pulse("to_blink");

    // Mode edge landing in the same cycle as a BLINK step.
    wait_tick(n);
    k = 9 - LAT;
    repeat (k) @(negedge clk);
    sw_mode = 1'b1;
    repeat (8 - k) @(negedge clk);
    check("coinc_tick_before", tick, 1);
    check("coinc_mode_before", mode, 1);
    @(negedge clk);
    exp_mode = 2;
    push_exp("coinc", 2'd2, 4'b0001);
    pop_check();
    check("coinc_tick_after", tick, 0);
    repeat (10) @(negedge clk);
    sw_mode = 1'b0;

    // Asynchronous reset mid-run, sw_mode held high across release.
    repeat (3) @(negedge clk);
    sw_mode = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    exp_mode = 0;
    push_exp("async_reset", 2'd0, 4'b0000);
    pop_check();
    check("async_reset_tick", tick, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (25) @(negedge clk);
    push_exp("no_spurious", 2'd0, 4'b0000);
    pop_check();
    sw_mode = 1'b0;
    repeat (8) @(negedge clk);
    mode_pulse("post_reset");

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
